store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-store queue directly downstream of the store data packager in the MEM stage.
- Accepts packaged stores (byte address, replicated write data, byte mask), holds up to DEPTH entries in order, and drains them one at a time to the L1 data cache write port with a req/ack handshake.
- Lets the pipeline retire stores without waiting on the cache.
- Flags read-after-write hazards for loads that target a word still held in the queue.

Parameters:
- DATA_WIDTH, 32, width of store data and addresses
- DEPTH, 4, number of queue entries; power of 2, minimum 2

Ports:
- clk  in  1  clock; rising-edge
- rstn  in  1  reset, asynchronous, active-low
- st_valid  in  1  packaged store presented
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  DATA_WIDTH  byte address of the store
- st_data  in  DATA_WIDTH  lane-replicated write data from the packager
- st_mask  in  DATA_WIDTH/8  byte-enable mask from the packager
- mem_req  out  1  write request to L1 D-cache
- mem_addr  out  DATA_WIDTH  word-aligned write address, low 2 bits always 0
- mem_wdata  out  DATA_WIDTH  write data
- mem_wmask  out  DATA_WIDTH/8  byte enables
- mem_ack  in  1  cache has accepted the current write
- ld_addr  in  DATA_WIDTH  address of the load currently in MEM
- ld_hazard  out  1  load word matches a buffered store
- empty  out  1  no entries held and no write in flight
- count  out  $clog2(DEPTH)+1  entries held, including the in-flight head

Behaviour:
- Reset: asynchronous on rstn low.
  - Clears all entries, pointers and count; count=0, empty=1, st_ready=1.
  - mem_req=0; mem_addr, mem_wdata and mem_wmask all 0; FSM=IDLE.
  - Reset mid-transfer abandons the in-flight write. Any mem_ack arriving after reset is ignored.
- Storage: circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. count is separate so full and empty are unambiguous.
- Enqueue: push occurs when st_valid && st_ready.
  - st_ready = (count != DEPTH), combinational from registered state.
  - st_ready does not look ahead to a same-cycle pop, so a full buffer refuses a push even while mem_ack is high.
  - The stored address is {st_addr[DATA_WIDTH-1:2],2'b00}.
- Zero mask: a handshaked store with st_mask==0 (misaligned sh) is accepted and discarded. It is not stored, count is unchanged, and no memory write is issued.
- FSM:
  - IDLE: if count!=0, load the head entry into the mem_* registers and set mem_req=1 next cycle; go to REQ.
  - REQ: mem_req, mem_addr, mem_wdata and mem_wmask hold stable until mem_ack=1.
  - On ack, pop the head. If entries remain after the pop (count-1 != 0), load the next head in the same edge and stay in REQ, giving back-to-back requests with no bubble. Otherwise clear mem_req and mem_wmask and go to IDLE.
  - mem_ack while mem_req=0 is ignored.
- Latency: a store pushed into an empty buffer at edge N drives mem_req=1 after edge N+1. With single-cycle ack, it pops at edge N+2.
- Simultaneous push and pop: both take effect and count is unchanged. A push into a buffer holding only the head while that head is acked becomes the next head and is issued the following cycle.
- The in-flight head stays counted and stays in storage until acked.
- ld_hazard: combinational. It is 1 when any held entry (head included) has addr[DATA_WIDTH-1:2] == ld_addr[DATA_WIDTH-1:2].
  - There is no forwarding; the pipeline stalls the load while ld_hazard=1.
  - A store being pushed in the same cycle is not compared.
- empty = (count==0). The pipeline uses it for fence and CSR drain.
- Ordering: strictly FIFO; no coalescing; no reordering.

Test Plan:
- Reset, then push st_addr=0x100, st_data=0xDEADBEEF, st_mask=4'b1111. Required: mem_req rises one cycle later with mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_wmask=4'b1111; with ack held off 3 cycles the outputs stay stable; after ack, count=0, empty=1, mem_req=0.
- Push 4 stores (addresses 0x10, 0x14, 0x18, 0x1C) with mem_ack held 0. Required: after the 4th push st_ready=0 and count=4; a 5th st_valid is not accepted. Then assert ack every cycle: the writes appear in address order on consecutive cycles with mem_req continuously 1, and st_ready returns the cycle after the first pop.
- Push sb to 0x203 with st_data=0x5A5A5A5A, st_mask=4'b1000. Required: mem_addr=0x200, mem_wmask=4'b1000. Push with st_mask=0 at 0x301: accepted, count unchanged, no write issued.
- Hold a store at 0x40 un-acked. Required: ld_addr=0x42 gives ld_hazard=1, ld_addr=0x44 gives 0; after ack and pop, ld_addr=0x42 gives 0.
- With the head waiting and 1 entry held, push a new store in the same cycle as mem_ack. Required: count stays 1 and the new store is requested on the very next cycle.
- Drive rstn low mid-REQ with 3 entries held. Required: mem_req=0 and count=0 immediately (asynchronously); a late mem_ack after reset is released produces no pop and no underflow.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-store queue between the store packager and the L1 D-cache write port.
// Holds up to DEPTH word-aligned stores in order and drains them with a req/ack handshake.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [DATA_WIDTH-1:0]     st_addr,
  input  logic [DATA_WIDTH-1:0]     st_data,
  input  logic [DATA_WIDTH/8-1:0]   st_mask,
  output logic                      mem_req,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wmask,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     ld_addr,
  output logic                      ld_hazard,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int MASK_W = DATA_WIDTH / 8;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [MASK_W-1:0]       mask_q [DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [PTR_W-1:0]        head_nxt;
  logic                    push;
  logic                    pop;
  logic                    unused_addr_bits;

  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
    return {a[DATA_WIDTH-1:2], 2'b00};
  endfunction

  assign st_ready = (count != CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign head_nxt = head + PTR_W'(1);
  // Zero-mask stores complete the handshake but are dropped here.
  assign push     = st_valid && st_ready && (st_mask != '0);
  assign pop      = (state == REQ) && mem_ack;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= word_align(st_addr);
      data_q[tail] <= st_data;
      mask_q[tail] <= st_mask;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head_nxt;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            mem_req   <= 1'b1;
            mem_addr  <= addr_q[head];
            mem_wdata <= data_q[head];
            mem_wmask <= mask_q[head];
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (count > CNT_W'(1)) begin
              mem_addr  <= addr_q[head_nxt];
              mem_wdata <= data_q[head_nxt];
              mem_wmask <= mask_q[head_nxt];
            end else if (push) begin
              // The store arriving with the last ack becomes the next head directly.
              mem_addr  <= word_align(st_addr);
              mem_wdata <= st_data;
              mem_wmask <= st_mask;
            end else begin
              mem_req   <= 1'b0;
              mem_wmask <= '0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    logic [PTR_W-1:0] rel;
    ld_hazard = 1'b0;
    rel       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - head;
      if ((CNT_W'(rel) < count) &&
          (addr_q[i][DATA_WIDTH-1:2] == ld_addr[DATA_WIDTH-1:2]))
        ld_hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
module tb_store_buffer;

  logic        clk;
  logic        rstn;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        empty;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  store_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mask  = m;
  endtask

  initial begin
    rstn = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
    mem_ack = 1'b0; ld_addr = '0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_ready", 32'(st_ready), 1);
    check("rst_req", 32'(mem_req), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wmask", 32'(mem_wmask), 0);
    #5 rstn = 1'b1;
    step();

    // Single store, ack delayed three cycles
    drive_store(32'h100, 32'hDEADBEEF, 4'b1111);
    step();
    st_valid = 1'b0;
    check("t1_cnt_after_push", 32'(count), 1);
    check("t1_req_not_yet", 32'(mem_req), 0);
    step();
    check("t1_req", 32'(mem_req), 1);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_wdata", mem_wdata, 32'hDEADBEEF);
    check("t1_wmask", 32'(mem_wmask), 32'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_hold_req", 32'(mem_req), 1);
      check("t1_hold_addr", mem_addr, 32'h100);
      check("t1_hold_wdata", mem_wdata, 32'hDEADBEEF);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("t1_cnt_done", 32'(count), 0);
    check("t1_empty_done", 32'(empty), 1);
    check("t1_req_done", 32'(mem_req), 0);
    check("t1_wmask_done", 32'(mem_wmask), 0);

    // Fill to full, refuse fifth, drain back-to-back
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h10 + 32'(i) * 4, 32'h1000 + 32'(i), 4'b1111);
      step();
    end
    check("t2_full_ready", 32'(st_ready), 0);
    check("t2_full_cnt", 32'(count), 4);
    drive_store(32'h20, 32'h2000, 4'b1111);
    step();
    st_valid = 1'b0;
    check("t2_fifth_cnt", 32'(count), 4);
    mem_ack = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("t2_drain_req", 32'(mem_req), 1);
      check("t2_drain_addr", mem_addr, 32'h10 + 32'(j) * 4);
      check("t2_drain_wdata", mem_wdata, 32'h1000 + 32'(j));
      check("t2_drain_cnt", 32'(count), 32'(4 - j));
      check("t2_drain_ready", 32'(st_ready), (j == 0) ? 32'd0 : 32'd1);
      step();
    end
    mem_ack = 1'b0;
    check("t2_end_req", 32'(mem_req), 0);
    check("t2_end_cnt", 32'(count), 0);

    // Byte store alignment and zero-mask discard
    drive_store(32'h203, 32'h5A5A5A5A, 4'b1000);
    step();
    st_valid = 1'b0;
    step();
    check("t3_addr", mem_addr, 32'h200);
    check("t3_wmask", 32'(mem_wmask), 32'h8);
    check("t3_wdata", mem_wdata, 32'h5A5A5A5A);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    drive_store(32'h301, 32'h12345678, 4'b0000);
    #1;
    check("t3_zero_ready", 32'(st_ready), 1);
    step();
    st_valid = 1'b0;
    check("t3_zero_cnt", 32'(count), 0);
    check("t3_zero_empty", 32'(empty), 1);
    step();
    step();
    check("t3_zero_noreq", 32'(mem_req), 0);

    // Load hazard detection
    drive_store(32'h40, 32'hCAFE0000, 4'b1111);
    step();
    st_valid = 1'b0;
    ld_addr = 32'h42;
    #1;
    check("t4_haz_same", 32'(ld_hazard), 1);
    ld_addr = 32'h44;
    #1;
    check("t4_haz_next", 32'(ld_hazard), 0);
    step();
    ld_addr = 32'h42;
    #1;
    check("t4_haz_inflight", 32'(ld_hazard), 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    check("t4_haz_popped", 32'(ld_hazard), 0);
    ld_addr = '0;

    // Push coinciding with ack of the only entry
    drive_store(32'h80, 32'hA1, 4'b1111);
    step();
    st_valid = 1'b0;
    step();
    check("t5_pre_addr", mem_addr, 32'h80);
    check("t5_pre_cnt", 32'(count), 1);
    mem_ack = 1'b1;
    drive_store(32'h84, 32'hB2, 4'b0011);
    step();
    mem_ack = 1'b0;
    st_valid = 1'b0;
    check("t5_cnt", 32'(count), 1);
    check("t5_req", 32'(mem_req), 1);
    check("t5_addr", mem_addr, 32'h84);
    check("t5_wdata", mem_wdata, 32'hB2);
    check("t5_wmask", 32'(mem_wmask), 32'h3);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("t5_end_cnt", 32'(count), 0);

    // Asynchronous reset mid-transfer, late ack ignored
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h500 + 32'(i) * 4, 32'h50 + 32'(i), 4'b1111);
      step();
    end
    st_valid = 1'b0;
    step();
    check("t6_pre_cnt", 32'(count), 3);
    check("t6_pre_req", 32'(mem_req), 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_async_req", 32'(mem_req), 0);
    check("t6_async_cnt", 32'(count), 0);
    check("t6_async_empty", 32'(empty), 1);
    mem_ack = 1'b1;
    step();
    #3 rstn = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    check("t6_late_cnt", 32'(count), 0);
    check("t6_late_req", 32'(mem_req), 0);
    check("t6_late_empty", 32'(empty), 1);
    check("t6_late_ready", 32'(st_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
